// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared definitions for the systolic AXI-Stream matrix
//               multiplier: controller state encoding and default parameter
//               values used by systolic_axis_array_p and systolic_pe.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Controller states: LOAD accepts k-beats, DRAIN lets the wavefront
  // flush through the array, OUT presents the finished matrix.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  localparam int SYS_N_DEF        = 3;
  localparam int SYS_DW_DEF       = 8;
  localparam int SYS_AW_DEF       = 16;
  localparam int SYS_K_MAX_DEF    = 16;
  localparam int SYS_SATURATE_DEF = 0;

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pe
// Description : One processing element of the systolic array. Multiplies the
//               incoming a/b operands, adds the product into an AW-bit
//               accumulator (wrapping or saturating) and forwards a to the
//               right and b downward through one register each.
// Ports       : clk, rst_n     - clock, async active-low reset
//               clr            - synchronous clear of all PE state
//               a_in / b_in    - operands from left / above
//               a_out / b_out  - registered operands to right / below
//               acc            - accumulator value
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW       = SYS_DW_DEF,
  parameter int AW       = SYS_AW_DEF,
  parameter int SATURATE = SYS_SATURATE_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [2*DW-1:0] prod;
  logic [AW:0]     sum;
  logic [AW-1:0]   acc_next;

  assign prod = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
  // One extra bit catches the carry out of the accumulator for saturation.
  assign sum  = {1'b0, acc} + {{(AW+1-2*DW){1'b0}}, prod};

  // Once the accumulator is all ones, any further product keeps the carry
  // set, so the saturated value sticks for the rest of the job.
  always_comb begin
    acc_next = sum[AW-1:0];
    if ((SATURATE != 0) && sum[AW]) begin
      acc_next = {AW{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_axis_array_p.sv
`default_nettype none
// ============================================================================
// Module      : systolic_axis_array_p
// Description : N x N output-stationary systolic matrix multiplier with
//               AXI-Stream style input beats and a single-beat result.
//               Each input beat carries column k of A and row k of B; after
//               the last beat the array drains and presents C = A x B.
// Ports       : axi_clk, axi_rst_n          - clock, async active-low reset
//               s_axis_valid/data/last/ready - operand beat stream
//               m_axis_valid/data/ready      - result matrix
//               k_overflow                   - pulse when K_MAX beats arrive
//                                              without s_axis_last
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_axis_array_p
  import systolic_pkg::*;
#(
  parameter int N        = SYS_N_DEF,
  parameter int DW       = SYS_DW_DEF,
  parameter int AW       = SYS_AW_DEF,
  parameter int K_MAX    = SYS_K_MAX_DEF,
  parameter int SATURATE = SYS_SATURATE_DEF
) (
  input  logic              axi_clk,
  input  logic              axi_rst_n,
  input  logic              s_axis_valid,
  input  logic [2*N*DW-1:0] s_axis_data,
  input  logic              s_axis_last,
  output logic              s_axis_ready,
  output logic              m_axis_valid,
  output logic [N*N*AW-1:0] m_axis_data,
  input  logic              m_axis_ready,
  output logic              k_overflow
);

  localparam int BCW = $clog2(K_MAX + 1);
  localparam int DCW = $clog2(2 * N);

  state_t          state;
  logic [BCW-1:0]  beat_cnt;
  logic [DCW-1:0]  drain_cnt;

  logic accept;
  logic out_hs;

  assign accept = s_axis_valid & s_axis_ready;
  assign out_hs = m_axis_valid & m_axis_ready;

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state        <= ST_LOAD;
      s_axis_ready <= 1'b1;
      m_axis_valid <= 1'b0;
      k_overflow   <= 1'b0;
      beat_cnt     <= '0;
      drain_cnt    <= '0;
    end else begin
      k_overflow <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (s_axis_last) begin
              state        <= ST_DRAIN;
              s_axis_ready <= 1'b0;
              drain_cnt    <= '0;
            end else if (beat_cnt == BCW'(K_MAX - 1)) begin
              state        <= ST_DRAIN;
              s_axis_ready <= 1'b0;
              drain_cnt    <= '0;
              k_overflow   <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // The last product reaches PE(N-1,N-1) 2N-1 edges after the final
          // beat; valid rises on the edge after that.
          if (drain_cnt == DCW'(2 * N - 1)) begin
            state        <= ST_OUT;
            m_axis_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (m_axis_ready) begin
            state        <= ST_LOAD;
            m_axis_valid <= 1'b0;
            s_axis_ready <= 1'b1;
            beat_cnt     <= '0;
          end
        end
        default: begin
          state        <= ST_LOAD;
          s_axis_ready <= 1'b1;
          m_axis_valid <= 1'b0;
          beat_cnt     <= '0;
          drain_cnt    <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Operand skew and PE grid
  // --------------------------------------------------------------------------
  logic [DW-1:0] a_h [N][N+1];   // a_h[i][j] feeds PE(i,j) from the left
  logic [DW-1:0] b_v [N+1][N];   // b_v[i][j] feeds PE(i,j) from above
  logic [AW-1:0] acc [N][N];
  logic [DW-1:0] a_unused [N];   // operands leaving the right edge
  logic [DW-1:0] b_unused [N];   // operands leaving the bottom edge

  // Row i passes through i+1 registers, column j through j+1, so operand k
  // meets at PE(i,j) i+j cycles after its first register stage. Cycles
  // without an accepted beat inject zeros, which add nothing.
  for (genvar i = 0; i < N; i++) begin : g_row_skew
    logic [DW-1:0] sk [0:i];
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
        for (int t = 0; t <= i; t++) sk[t] <= '0;
      end else if (out_hs) begin
        for (int t = 0; t <= i; t++) sk[t] <= '0;
      end else begin
        sk[0] <= accept ? s_axis_data[i*DW +: DW] : '0;
        for (int t = 1; t <= i; t++) sk[t] <= sk[t-1];
      end
    end
    assign a_h[i][0] = sk[i];
    assign a_unused[i] = a_h[i][N];
  end

  for (genvar j = 0; j < N; j++) begin : g_col_skew
    logic [DW-1:0] sk [0:j];
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
        for (int t = 0; t <= j; t++) sk[t] <= '0;
      end else if (out_hs) begin
        for (int t = 0; t <= j; t++) sk[t] <= '0;
      end else begin
        sk[0] <= accept ? s_axis_data[(N+j)*DW +: DW] : '0;
        for (int t = 1; t <= j; t++) sk[t] <= sk[t-1];
      end
    end
    assign b_v[0][j] = sk[j];
    assign b_unused[j] = b_v[N][j];
  end

  for (genvar i = 0; i < N; i++) begin : g_pe_row
    for (genvar j = 0; j < N; j++) begin : g_pe_col
      systolic_pe #(
        .DW       (DW),
        .AW       (AW),
        .SATURATE (SATURATE)
      ) u_pe (
        .clk   (axi_clk),
        .rst_n (axi_rst_n),
        .clr   (out_hs),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc[i][j])
      );
      // Accumulators are quiescent once DRAIN ends, so they drive the
      // result bus directly and stay stable throughout OUT.
      assign m_axis_data[(i*N+j)*AW +: AW] = acc[i][j];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_axis_array_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_axis_array_p
// Description : Directed self-checking bench for systolic_axis_array_p with
//               N=3, DW=8, AW=16, K_MAX=16; a wrapping and a saturating
//               instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_axis_array_p;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 16;

  logic              axi_clk = 1'b0;
  logic              axi_rst_n;
  logic              s_axis_valid;
  logic [2*N*DW-1:0] s_axis_data;
  logic              s_axis_last;
  logic              m_axis_ready;

  wire               s_axis_ready, s_axis_ready_sat;
  wire               m_axis_valid, m_axis_valid_sat;
  wire [N*N*AW-1:0]  m_axis_data,  m_axis_data_sat;
  wire               k_overflow,   k_overflow_sat;

  always #5 axi_clk = ~axi_clk;

  systolic_axis_array_p #(.N(N), .DW(DW), .AW(AW), .K_MAX(16), .SATURATE(0)) dut (
    .axi_clk      (axi_clk),
    .axi_rst_n    (axi_rst_n),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_ready (m_axis_ready),
    .k_overflow   (k_overflow)
  );

  systolic_axis_array_p #(.N(N), .DW(DW), .AW(AW), .K_MAX(16), .SATURATE(1)) dut_sat (
    .axi_clk      (axi_clk),
    .axi_rst_n    (axi_rst_n),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready_sat),
    .m_axis_valid (m_axis_valid_sat),
    .m_axis_data  (m_axis_data_sat),
    .m_axis_ready (m_axis_ready),
    .k_overflow   (k_overflow_sat)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_c [9];
  int lat;
  int ovf_seen;
  logic [N*N*AW-1:0] exp_v;

  function automatic logic [2*N*DW-1:0] beat(int a0, int a1, int a2, int b0, int b1, int b2);
    return {8'(b2), 8'(b1), 8'(b0), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [31:0] c_of(logic [N*N*AW-1:0] d, int idx);
    return {16'b0, d[idx*AW +: AW]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_mat(input string tag, input logic [N*N*AW-1:0] d);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s[%0d]", tag, k), c_of(d, k), 32'(exp_c[k]));
  endtask

  task automatic send(input logic [2*N*DW-1:0] d, input logic last);
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = last;
    @(posedge axi_clk); #1;
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge axi_clk); #1;
    end
  endtask

  // Counts edges from the current point until m_axis_valid, bounded.
  task automatic wait_valid();
    lat = 0;
    ovf_seen = 0;
    do begin
      @(posedge axi_clk); #1;
      lat++;
      if (k_overflow) ovf_seen++;
    end while (!m_axis_valid && lat < 60);
  endtask

  task automatic job1();
    send(beat(1, 4, 7, 1, 2, 3), 1'b0);
    send(beat(2, 5, 8, 4, 5, 6), 1'b0);
    send(beat(3, 6, 9, 7, 8, 9), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    axi_rst_n    = 1'b0;
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    s_axis_last  = 1'b0;
    m_axis_ready = 1'b1;
    idle(3);
    chk("rst_valid", {31'b0, m_axis_valid}, 0);
    chk("rst_ovf",   {31'b0, k_overflow}, 0);
    chk("rst_data",  {31'b0, |m_axis_data}, 0);
    @(negedge axi_clk) axi_rst_n = 1'b1;
    @(posedge axi_clk); #1;
    chk("rel_ready", {31'b0, s_axis_ready}, 1);
    chk("rel_valid", {31'b0, m_axis_valid}, 0);

    // Job 1: 3x3 reference product
    job1();
    wait_valid();
    chk("j1_lat", lat, 6);
    exp_c = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    chk_mat("j1_c", m_axis_data);
    chk_mat("j1_sat_c", m_axis_data_sat);
    idle(1);
    chk("j1_valid_once", {31'b0, m_axis_valid}, 0);
    chk("j1_ready_back", {31'b0, s_axis_ready}, 1);

    // Job 2 back-to-back: no residue from job 1
    send(beat(10, 13, 16, 1, 2, 3), 1'b0);
    send(beat(11, 14, 17, 4, 5, 6), 1'b0);
    send(beat(12, 15, 18, 7, 8, 9), 1'b1);
    wait_valid();
    chk("j2_lat", lat, 6);
    chk("j2_c0", c_of(m_axis_data, 0), 138);
    chk("j2_c1", c_of(m_axis_data, 1), 171);
    chk("j2_c2", c_of(m_axis_data, 2), 204);
    chk("j2_c8", c_of(m_axis_data, 8), 312);
    idle(1);

    // Job 1 with idle bubbles, then a 10-cycle output stall with valid input
    m_axis_ready = 1'b0;
    send(beat(1, 4, 7, 1, 2, 3), 1'b0);
    idle(2);
    send(beat(2, 5, 8, 4, 5, 6), 1'b0);
    idle(1);
    send(beat(3, 6, 9, 7, 8, 9), 1'b1);
    wait_valid();
    chk("bub_lat", lat, 6);
    exp_c = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    chk_mat("bub_c", m_axis_data);
    for (int k = 0; k < 9; k++) exp_v[k*AW +: AW] = 16'(exp_c[k]);
    s_axis_valid = 1'b1;
    s_axis_data  = beat(99, 99, 99, 99, 99, 99);
    for (int t = 0; t < 10; t++) begin
      @(posedge axi_clk); #1;
      chk("stall_valid", {31'b0, m_axis_valid}, 1);
      chk("stall_ready", {31'b0, s_axis_ready}, 0);
      chk("stall_data",  {31'b0, m_axis_data === exp_v}, 1);
    end
    m_axis_ready = 1'b1;
    @(posedge axi_clk); #1;
    s_axis_valid = 1'b0;
    chk("stall_rel_valid", {31'b0, m_axis_valid}, 0);
    chk("stall_rel_ready", {31'b0, s_axis_ready}, 1);

    // K=1 job; also proves nothing was accepted during the stall
    send(beat(1, 2, 3, 4, 5, 6), 1'b1);
    wait_valid();
    chk("k1_lat", lat, 6);
    chk("k1_c0", c_of(m_axis_data, 0), 4);
    chk("k1_c4", c_of(m_axis_data, 4), 10);
    chk("k1_c8", c_of(m_axis_data, 8), 18);
    idle(1);

    // Two beats of all-255: wrap vs saturate
    send(beat(255, 255, 255, 255, 255, 255), 1'b0);
    send(beat(255, 255, 255, 255, 255, 255), 1'b1);
    wait_valid();
    exp_c = '{64514, 64514, 64514, 64514, 64514, 64514, 64514, 64514, 64514};
    chk_mat("wrap_c", m_axis_data);
    exp_c = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
    chk_mat("sat_c", m_axis_data_sat);
    idle(1);

    // K_MAX beats without last
    for (int b = 0; b < 16; b++) begin
      send(beat(1, 1, 1, 1, 1, 1), 1'b0);
      if (b == 14) begin
        chk("ovf_pre",       {31'b0, k_overflow}, 0);
        chk("ovf_pre_ready", {31'b0, s_axis_ready}, 1);
      end
    end
    chk("ovf_pulse", {31'b0, k_overflow}, 1);
    chk("ovf_ready", {31'b0, s_axis_ready}, 0);
    wait_valid();
    chk("ovf_single", ovf_seen, 0);
    chk("ovf_lat", lat, 6);
    chk("ovf_c0", c_of(m_axis_data, 0), 16);
    chk("ovf_c8", c_of(m_axis_data, 8), 16);
    idle(1);

    // Reset in the middle of DRAIN
    job1();
    idle(2);
    axi_rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, m_axis_valid}, 0);
    chk("mrst_ready", {31'b0, s_axis_ready}, 1);
    chk("mrst_ovf",   {31'b0, k_overflow}, 0);
    chk("mrst_data",  {31'b0, |m_axis_data}, 0);
    @(negedge axi_clk) axi_rst_n = 1'b1;
    @(posedge axi_clk); #1;
    job1();
    wait_valid();
    chk("mrst_lat", lat, 6);
    exp_c = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    chk_mat("mrst_c", m_axis_data);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
